// File: rtl/axi4lite_regbank.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : axi4lite_regbank                                             |
// | Description : AXI4-Lite slave with built-in register file, per-register    |
// |               read-only / self-clearing modes and DECERR/SLVERR responses. |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module axi4lite_regbank #(
    parameter int                    C_S_AXI_DATA_WIDTH = 32,
    parameter int                    C_S_AXI_ADDR_WIDTH = 11,
    parameter int                    REGISTER_N         = 8,
    parameter logic [REGISTER_N-1:0] RO_MASK            = '0,
    parameter logic [REGISTER_N-1:0] SC_MASK            = '0
) (
    input  logic                                     S_AXI_ACLK,
    input  logic                                     S_AXI_ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]            S_AXI_AWADDR,
    input  logic [2:0]                               S_AXI_AWPROT,
    input  logic                                     S_AXI_AWVALID,
    output logic                                     S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]            S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]          S_AXI_WSTRB,
    input  logic                                     S_AXI_WVALID,
    output logic                                     S_AXI_WREADY,
    output logic [1:0]                               S_AXI_BRESP,
    output logic                                     S_AXI_BVALID,
    input  logic                                     S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]            S_AXI_ARADDR,
    input  logic [2:0]                               S_AXI_ARPROT,
    input  logic                                     S_AXI_ARVALID,
    output logic                                     S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]            S_AXI_RDATA,
    output logic [1:0]                               S_AXI_RRESP,
    output logic                                     S_AXI_RVALID,
    input  logic                                     S_AXI_RREADY,
    output logic [REGISTER_N*C_S_AXI_DATA_WIDTH-1:0] reg_q,
    output logic [REGISTER_N-1:0]                    reg_wr_pulse,
    output logic [REGISTER_N-1:0]                    reg_rd_pulse,
    input  logic [REGISTER_N*C_S_AXI_DATA_WIDTH-1:0] reg_ro_din
);

    localparam int c_DW     = C_S_AXI_DATA_WIDTH;
    localparam int c_STRB_W = C_S_AXI_DATA_WIDTH / 8;
    localparam int c_LSB    = $clog2(c_STRB_W);
    localparam int c_IDX_W  = C_S_AXI_ADDR_WIDTH - c_LSB;

    localparam logic [0:0] c_W_IDLE = 1'b0;
    localparam logic [0:0] c_W_RESP = 1'b1;
    localparam logic [0:0] c_R_IDLE = 1'b0;
    localparam logic [0:0] c_R_DATA = 1'b1;

    localparam logic [1:0] c_OKAY   = 2'b00;
    localparam logic [1:0] c_SLVERR = 2'b10;
    localparam logic [1:0] c_DECERR = 2'b11;

    logic [c_DW-1:0]       r_regs [REGISTER_N];

    logic [0:0]            r_wstate;
    logic                  r_aw_held;
    logic                  r_w_held;
    logic [c_IDX_W-1:0]    r_awidx;
    logic [c_DW-1:0]       r_wdata;
    logic [c_STRB_W-1:0]   r_wstrb;
    logic [1:0]            r_bresp;
    logic [REGISTER_N-1:0] r_wr_pulse;

    logic [0:0]            r_rstate;
    logic [c_DW-1:0]       r_rdata;
    logic [1:0]            r_rresp;
    logic [REGISTER_N-1:0] r_rd_pulse;

    logic                  w_aw_hs;
    logic                  w_w_hs;
    logic                  w_commit;
    logic [c_IDX_W-1:0]    w_widx;
    logic [c_DW-1:0]       w_wdata;
    logic [c_STRB_W-1:0]   w_wstrb;
    logic [REGISTER_N-1:0] w_wsel;
    logic [1:0]            w_bresp;

    logic                  w_ar_hs;
    logic [c_IDX_W-1:0]    w_ridx;
    logic [REGISTER_N-1:0] w_rsel;
    logic [c_DW-1:0]       w_rdata;
    logic [1:0]            w_rresp;

    logic                  w_unused;

    assign S_AXI_AWREADY = (r_wstate == c_W_IDLE) & ~r_aw_held;
    assign S_AXI_WREADY  = (r_wstate == c_W_IDLE) & ~r_w_held;
    assign S_AXI_BVALID  = (r_wstate == c_W_RESP);
    assign S_AXI_BRESP   = r_bresp;
    assign S_AXI_ARREADY = (r_rstate == c_R_IDLE);
    assign S_AXI_RVALID  = (r_rstate == c_R_DATA);
    assign S_AXI_RDATA   = r_rdata;
    assign S_AXI_RRESP   = r_rresp;
    assign reg_wr_pulse  = r_wr_pulse;
    assign reg_rd_pulse  = r_rd_pulse;

    // Protection bits, byte-offset address bits and RW-slot status inputs carry no meaning here.
    assign w_unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR, S_AXI_ARADDR, reg_ro_din};

    generate
        for (genvar gi = 0; gi < REGISTER_N; gi++) begin : g_reg_q
            assign reg_q[gi*c_DW +: c_DW] = r_regs[gi];
        end
    endgenerate

    // A captured beat and a beat handshaking this cycle are treated alike, so commit
    // happens on the very edge at which the second half arrives.
    always_comb begin
        w_aw_hs  = S_AXI_AWVALID & S_AXI_AWREADY;
        w_w_hs   = S_AXI_WVALID & S_AXI_WREADY;
        w_commit = (r_wstate == c_W_IDLE) & (r_aw_held | w_aw_hs) & (r_w_held | w_w_hs);
        w_widx   = r_aw_held ? r_awidx : S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:c_LSB];
        w_wdata  = r_w_held ? r_wdata : S_AXI_WDATA;
        w_wstrb  = r_w_held ? r_wstrb : S_AXI_WSTRB;
        w_wsel   = '0;
        for (int i = 0; i < REGISTER_N; i++) begin
            w_wsel[i] = (w_widx == c_IDX_W'(i));
        end
        if (w_wsel == '0) begin
            w_bresp = c_DECERR;
        end else if ((w_wsel & RO_MASK) != '0) begin
            w_bresp = c_SLVERR;
        end else begin
            w_bresp = c_OKAY;
        end
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            r_wstate   <= c_W_IDLE;
            r_aw_held  <= 1'b0;
            r_w_held   <= 1'b0;
            r_awidx    <= '0;
            r_wdata    <= '0;
            r_wstrb    <= '0;
            r_bresp    <= c_OKAY;
            r_wr_pulse <= '0;
        end else begin
            r_wr_pulse <= '0;
            if (r_wstate == c_W_IDLE) begin
                if (w_commit) begin
                    r_wstate   <= c_W_RESP;
                    r_aw_held  <= 1'b0;
                    r_w_held   <= 1'b0;
                    r_bresp    <= w_bresp;
                    r_wr_pulse <= w_wsel & ~RO_MASK;
                end else begin
                    if (w_aw_hs) begin
                        r_aw_held <= 1'b1;
                        r_awidx   <= S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:c_LSB];
                    end
                    if (w_w_hs) begin
                        r_w_held <= 1'b1;
                        r_wdata  <= S_AXI_WDATA;
                        r_wstrb  <= S_AXI_WSTRB;
                    end
                end
            end else if (S_AXI_BREADY) begin
                r_wstate <= c_W_IDLE;
            end
        end
    end

    // Self-clear keys off the commit pulse so the written value lives exactly one cycle;
    // a fresh commit on that same edge takes priority.
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            for (int i = 0; i < REGISTER_N; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < REGISTER_N; i++) begin
                if (!RO_MASK[i]) begin
                    if (w_commit && w_wsel[i]) begin
                        for (int b = 0; b < c_STRB_W; b++) begin
                            if (w_wstrb[b]) begin
                                r_regs[i][b*8 +: 8] <= w_wdata[b*8 +: 8];
                            end
                        end
                    end else if (SC_MASK[i] && r_wr_pulse[i]) begin
                        r_regs[i] <= '0;
                    end
                end
            end
        end
    end

    always_comb begin
        w_ar_hs = S_AXI_ARVALID & (r_rstate == c_R_IDLE);
        w_ridx  = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:c_LSB];
        w_rsel  = '0;
        w_rdata = '0;
        for (int i = 0; i < REGISTER_N; i++) begin
            w_rsel[i] = (w_ridx == c_IDX_W'(i));
            if (w_rsel[i]) begin
                w_rdata = RO_MASK[i] ? reg_ro_din[i*c_DW +: c_DW] : r_regs[i];
            end
        end
        w_rresp = (w_rsel == '0) ? c_DECERR : c_OKAY;
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            r_rstate   <= c_R_IDLE;
            r_rdata    <= '0;
            r_rresp    <= c_OKAY;
            r_rd_pulse <= '0;
        end else begin
            r_rd_pulse <= '0;
            if (w_ar_hs) begin
                r_rstate   <= c_R_DATA;
                r_rdata    <= w_rdata;
                r_rresp    <= w_rresp;
                r_rd_pulse <= w_rsel;
            end else if ((r_rstate == c_R_DATA) && S_AXI_RREADY) begin
                r_rstate <= c_R_IDLE;
            end
        end
    end

endmodule
`default_nettype wire
